// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, single-outstanding instruction fetch and next-PC selection
// for the single-cycle MIPS core. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] rs_data,
    input  logic        ex_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam logic [1:0] c_NPC_PLUS4  = 2'b00;
    localparam logic [1:0] c_NPC_BRANCH = 2'b01;
    localparam logic [1:0] c_NPC_JUMP   = 2'b10;
    localparam logic [1:0] c_NPC_JR     = 2'b11;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_err;
    logic [31:0] r_retire_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    always_comb begin
        w_npc = w_pc_plus4;
        case (NPCOp)
            c_NPC_PLUS4:  w_npc = w_pc_plus4;
            c_NPC_BRANCH: w_npc = w_pc_plus4 + w_br_off;
            c_NPC_JUMP:   w_npc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            c_NPC_JR:     w_npc = rs_data;
            default:      w_npc = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_err         <= 1'b0;
            r_retire_cnt  <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_rvalid) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ex_done) begin
                        r_instr_valid <= 1'b0;
                        r_retire_cnt  <= r_retire_cnt + 32'd1;
                        // A misaligned target retires the instruction but freezes the PC.
                        if (w_npc[1:0] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERROR;
                        end else begin
                            r_pc    <= w_npc;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_ERROR: begin
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_instr_valid <= 1'b0;
                    r_err         <= 1'b1;
                    r_state       <= S_ERROR;
                end
            endcase
        end
    end

    // Gated by rstn so the request drops the moment reset is asserted.
    assign imem_req    = rstn && (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign err         = r_err;
    assign retire_cnt  = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit with a behavioural next-PC model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  NPCOp = 2'b00;
    logic [31:0] rs_data = 32'd0;
    logic        ex_done = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        err;
    logic [31:0] retire_cnt;

    ifetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rstn(rstn), .NPCOp(NPCOp), .rs_data(rs_data), .ex_done(ex_done),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .err(err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [63:0] sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic [31:0] word,
                                               input logic [1:0] op, input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        p4  = cur_pc + 32'd4;
        off = $signed(word[15:0]);
        case (op)
            2'd0:    return p4;
            2'd1:    return p4 + 32'(off * 4);
            2'd2:    return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
            default: return rs;
        endcase
    endfunction

    // Monitor: every new instruction presentation must match the oldest accepted fetch.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (rstn && instr_valid && !prev_v) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_instr", instr, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("mon_pc", pc, e[63:32]);
                chk("mon_instr", instr, e[31:0]);
                chk("mon_pc_plus4", pc_plus4, e[63:32] + 32'd4);
            end
        end
        prev_v = instr_valid;
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("rst_async_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_async_pc", pc, RESET_PC);
        chk("rst_async_req", {31'd0, imem_req}, 32'd0);
        m_pc  = RESET_PC;
        m_cnt = 32'd0;
        m_err = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid_hold", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        rstn = 1'b1;
        #1;
        chk("req_after_release", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] word, input int rdly, input bit noise);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < rdly; i++) begin
            chk("addr_stable", imem_addr, m_pc);
            imem_rvalid = 1'b0;
            ex_done = noise;
            NPCOp   = 2'(($urandom));
            @(negedge clk);
            ex_done = 1'b0;
            chk("req_held", {31'd0, imem_req}, 32'd1);
        end
        chk("fetch_addr", imem_addr, m_pc);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        sb.push_back({m_pc, word});
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
    endtask

    task automatic retire(input logic [31:0] word, input logic [1:0] op, input logic [31:0] rs,
                          input int edly, input bit noise);
        logic [31:0] npc;
        for (int i = 0; i < edly; i++) begin
            chk("hold_req_low", {31'd0, imem_req}, 32'd0);
            imem_rvalid = noise;
            imem_rdata  = $urandom;
            @(negedge clk);
            imem_rvalid = 1'b0;
            chk("hold_instr_stable", instr, word);
        end
        NPCOp   = op;
        rs_data = rs;
        ex_done = 1'b1;
        npc     = model_npc(m_pc, word, op, rs);
        m_cnt   = m_cnt + 32'd1;
        if (npc[1:0] != 2'b00) m_err = 1'b1;
        else                   m_pc  = npc;
        @(negedge clk);
        ex_done = 1'b0;
        chk("ret_pc", pc, m_pc);
        chk("ret_cnt", retire_cnt, m_cnt);
        chk("ret_err", {31'd0, err}, {31'd0, m_err});
        chk("ret_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic do_instr(input logic [31:0] word, input logic [1:0] op, input logic [31:0] rs,
                            input int rdly, input int edly, input bit noise);
        fetch(word, rdly, noise);
        retire(word, op, rs, edly, noise);
    endtask

    initial begin
        int c0;
        logic [31:0] w;
        m_pc = RESET_PC; m_cnt = 0; m_err = 0;

        do_reset();
        // Slow memory, then three back-to-back sequential instructions.
        do_instr(32'h2001_0001, 2'd0, 32'd0, 3, 0, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 3; i++) do_instr($urandom, 2'd0, 32'd0, 0, 0, 1'b0);
        chk("seq_cycles", 32'(cyc - c0), 32'd6);
        chk("seq_pc", pc, 32'h0000_3010);
        chk("seq_cnt", retire_cnt, 32'd4);

        do_instr(32'h1000_FFFE, 2'd1, 32'd0, 0, 0, 1'b0);
        chk("branch_back", pc, 32'h0000_300C);
        do_instr(32'h0000_0000, 2'd0, 32'd0, 1, 1, 1'b1);
        do_instr(32'h1000_0003, 2'd1, 32'd0, 0, 2, 1'b1);
        chk("branch_fwd", pc, 32'h0000_3020);
        do_instr(32'h0000_0008, 2'd3, 32'h9000_0000, 0, 0, 1'b0);
        do_instr(32'h0800_0100, 2'd2, 32'd0, 2, 0, 1'b1);
        chk("jump", pc, 32'h9000_0400);
        do_instr(32'h0000_0008, 2'd3, 32'h0000_4000, 0, 0, 1'b0);
        chk("jr", pc, 32'h0000_4000);
        do_instr(32'h0000_0008, 2'd3, 32'hFFFF_FFFC, 0, 0, 1'b0);
        do_instr(32'h0000_0000, 2'd0, 32'd0, 0, 0, 1'b0);
        chk("pc_wrap", pc, 32'h0000_0000);

        for (int i = 0; i < 150; i++) begin
            do_instr($urandom, 2'($urandom), $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        // Reset mid-HOLD, then accept the response still pending across release.
        fetch($urandom, 1, 1'b0);
        do_reset();
        do_instr(32'hDEAD_BEEF, 2'd0, 32'd0, 0, 0, 1'b0);
        do_instr($urandom, 2'd0, 32'd0, 0, 0, 1'b0);

        do_instr(32'h0000_0008, 2'd3, 32'h0000_4002, 0, 1, 1'b0);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_pc", pc, RESET_PC + 32'd8);
        for (int i = 0; i < 6; i++) begin
            ex_done     = 1'($urandom);
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            @(negedge clk);
            chk("err_req_low", {31'd0, imem_req}, 32'd0);
            chk("err_valid_low", {31'd0, instr_valid}, 32'd0);
            chk("err_pc_frozen", pc, m_pc);
            chk("err_cnt_frozen", retire_cnt, m_cnt);
        end
        ex_done = 1'b0;
        imem_rvalid = 1'b0;
        w = $urandom;
        do_reset();
        imem_rvalid = 1'b0;
        do_instr(w, 2'd0, 32'd0, 1, 0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch and program-counter stage of the single-cycle MIPS core. It sits directly upstream of the main control decoder. It owns the PC, fetches one instruction at a time from instruction memory over a request/valid handshake, and presents the instruction (opcode/funct fields feed the decoder) until the datapath retires it. On retirement it computes the next PC from the decoder's 2-bit NPCOp and advances.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `NPCOp`  in  2  next-PC select from the decoder: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR.
- `rs_data`  in  32  GPR[rs] value, used as the JR/JALR target.
- `ex_done`  in  1  datapath retires the presented instruction this cycle.
- `imem_req`  out  1  fetch request, held until `imem_rvalid`.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  registered instruction; Op = [31:26], Funct = [5:0].
- `instr_valid`  out  1  `instr` is valid for execution.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, used for the link value (WDSel_FromPC).
- `err`  out  1  sticky misaligned-target error.
- `retire_cnt`  out  32  count of retired instructions.

## Operation
- FSM states: FETCH, HOLD, ERROR.
- Reset (async, `rstn` = 0) gives:
  - state = FETCH, `pc` = RESET_PC, `instr` = 0, `instr_valid` = 0, `err` = 0, `retire_cnt` = 0.
  - `imem_req` = 0 while `rstn` is low.
- FETCH:
  - `imem_req` = 1 whenever `rstn` is high.
  - On `imem_rvalid` = 1: `instr` <= `imem_rdata`, `instr_valid` <= 1, go to HOLD.
- HOLD:
  - `imem_req` = 0; `instr` and `pc` are stable.
  - On `ex_done` = 1: `pc` <= NPC, `instr_valid` <= 0, `retire_cnt` += 1, go to FETCH.
  - If NPC[1:0] != 0: go to ERROR instead, `err` <= 1, `pc` unchanged, `retire_cnt` still incremented.
- NPC calculation (32-bit, carries beyond bit 31 dropped, PC wraps 0xFFFF_FFFC -> 0):
  - PLUS4: `pc + 4`.
  - BRANCH: `pc + 4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - JUMP: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - JR: `rs_data`.
- ERROR:
  - `imem_req` = 0, `instr_valid` = 0.
  - All inputs are ignored. Exit is by reset only.
- Ignored inputs:
  - `imem_rvalid` outside FETCH.
  - `ex_done` outside HOLD.
- `retire_cnt` wraps 0xFFFF_FFFF -> 0.

## Timing
- First `imem_req` is high in the first cycle `rstn` is high.
- Fetch latency: `instr_valid` rises on the edge where `imem_rvalid` is sampled high. `imem_rvalid` may arrive in the same cycle `imem_req` rises, or any number of cycles later.
- Minimum 2 cycles per instruction: one FETCH with immediate `rvalid`, one HOLD with immediate `ex_done`.
- NPC is combinational from `pc`, `instr`, `NPCOp`, `rs_data` during HOLD. It is sampled only at the `ex_done` edge.
- `imem_addr` is stable for the entire FETCH residency.
- Reset asserted mid-FETCH or mid-HOLD: all state returns to reset values immediately and asynchronously. A pending memory response after reset release is accepted only once `imem_req` is high again.

## Test plan
- Reset with RESET_PC = 0x3000, `imem_rvalid` returned 3 cycles after `imem_req`:
  - `imem_addr` = 0x3000 with `imem_req` held for 3 cycles.
  - `instr` = rdata and `instr_valid` = 1 on the next cycle.
- Sequential PLUS4, rvalid immediate, `ex_done` immediate, 4 instructions:
  - PCs 0x3000, 0x3004, 0x3008, 0x300C; 2 cycles each.
  - `retire_cnt` = 4.
- BRANCH:
  - pc = 0x3010, instr[15:0] = 0xFFFE -> next pc = 0x300C.
  - instr[15:0] = 0x0003 -> next pc = 0x3020.
- JUMP, pc = 0x9000_0000, instr[25:0] = 0x0000100 -> next pc = 0x9000_0400.
- JR:
  - `rs_data` = 0x0000_4000 -> pc = 0x4000.
  - `rs_data` = 0x0000_4002 -> `err` = 1, `imem_req` stays 0 until reset, pc unchanged.
- Robustness:
  - `ex_done` pulsed during FETCH is ignored.
  - `imem_rvalid` pulsed during HOLD does not change `instr`.
  - `rstn` low during HOLD clears `instr_valid` and `pc` to RESET_PC without waiting for a clock edge.
